uart_tx_param: RTL and testbench

- Parametrised UART transmitter; next generation of the fixed 8-bit, even-parity transmitter.
- Adds:
  - configurable data width;
  - internal baud-rate divider;
  - run-time parity select (none/even/odd) and 1 or 2 stop bits;
  - done pulse for back-to-back streaming.
- Sits between the host-side byte source and the serial line; pairs with the UART receiver.

---
 rtl/uart_tx_param.sv | 130 +++++++++++++
 tb/tb_uart_tx_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first,
// optional even/odd parity, one or two stop bits, internal baud divider.
module uart_tx_param #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] TX_data,
   input  logic              TX_start,
   input  logic [1:0]        par_mode,
   input  logic              stop2,
   output logic              TX_busy,
   output logic              TX_done,
   output logic              TX_out
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_W);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    baud_q;
   logic [BIT_W-1:0]    bit_q;
   logic [DATA_W-1:0]   shift_q;
   logic                par_en_q;
   logic                par_bit_q;
   logic                stop2_q;
   logic                stop_cnt_q;
   logic                tx_out_q;
   logic                busy_q;
   logic                done_q;

   logic                baud_tc_d;
   logic                last_bit_d;
   logic                par_en_d;
   logic                par_bit_d;

   always_comb begin
      baud_tc_d  = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
      last_bit_d = (bit_q == BIT_W'(DATA_W - 1));
      par_en_d   = (par_mode == 2'b01) || (par_mode == 2'b10);
      par_bit_d  = (^TX_data) ^ (par_mode == 2'b10);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         stop2_q    <= 1'b0;
         stop_cnt_q <= 1'b0;
         tx_out_q   <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
            if (TX_start) begin
               shift_q    <= TX_data;
               par_en_q   <= par_en_d;
               par_bit_q  <= par_bit_d;
               stop2_q    <= stop2;
               stop_cnt_q <= 1'b0;
               baud_q     <= '0;
               bit_q      <= '0;
               tx_out_q   <= 1'b0;
               busy_q     <= 1'b1;
               state_q    <= START;
            end
         end else if (!baud_tc_d) begin
            baud_q <= baud_q + CNT_W'(1);
         end else begin
            baud_q <= '0;
            case (state_q)
               START: begin
                  tx_out_q <= shift_q[0];
                  state_q  <= DATA;
               end
               DATA: begin
                  if (last_bit_d) begin
                     // parity-less frames go straight to the stop bit(s)
                     if (par_en_q) begin
                        tx_out_q <= par_bit_q;
                        state_q  <= PARITY;
                     end else begin
                        tx_out_q <= 1'b1;
                        state_q  <= STOP;
                     end
                  end else begin
                     bit_q    <= bit_q + BIT_W'(1);
                     shift_q  <= shift_q >> 1;
                     tx_out_q <= shift_q[1];
                  end
               end
               PARITY: begin
                  tx_out_q <= 1'b1;
                  state_q  <= STOP;
               end
               STOP: begin
                  if (stop2_q && !stop_cnt_q) begin
                     stop_cnt_q <= 1'b1;
                  end else begin
                     tx_out_q <= 1'b1;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= IDLE;
                  end
               end
               default: begin
                  tx_out_q <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            endcase
         end
      end
   end

   assign TX_out  = tx_out_q;
   assign TX_busy = busy_q;
   assign TX_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8-bit/16-clk instance for the main
// frame tests and a 7-bit/4-clk instance for the narrow configuration.
module tb_uart_tx_param;

   localparam int N     = 16;
   localparam int LIMIT = 400;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] TX_data = 8'h00;
   logic       TX_start = 1'b0;
   logic [1:0] par_mode = 2'b00;
   logic       stop2 = 1'b0;
   logic       TX_busy, TX_done, TX_out;

   logic [6:0] tx_data7 = 7'h00;
   logic       tx_start7 = 1'b0;
   logic       busy7, done7, out7;

   int n_tests = 0;
   int n_fail  = 0;

   logic line_s [0:LIMIT-1];

   always #5 CLK = ~CLK;

   uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(16)) u_dut8 (
      .CLK(CLK), .RST(RST), .TX_data(TX_data), .TX_start(TX_start),
      .par_mode(par_mode), .stop2(stop2),
      .TX_busy(TX_busy), .TX_done(TX_done), .TX_out(TX_out)
   );

   uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(4)) u_dut7 (
      .CLK(CLK), .RST(RST), .TX_data(tx_data7), .TX_start(tx_start7),
      .par_mode(2'b01), .stop2(1'b0),
      .TX_busy(busy7), .TX_done(done7), .TX_out(out7)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a request at a negedge; returns at the negedge of the first busy cycle.
   task automatic send(input logic [7:0] d, input logic [1:0] m, input logic s, input bit hold);
      TX_data  = d;
      par_mode = m;
      stop2    = s;
      TX_start = 1'b1;
      @(negedge CLK);
      if (!hold) TX_start = 1'b0;
   endtask

   // Called at the negedge of the first busy cycle; returns at the TX_done cycle.
   task automatic capture(input string tag, input logic [7:0] d, input logic [1:0] m,
                          input logic s, input logic exp_par, input int exp_len,
                          input int poke_at, input logic [7:0] nd, input logic [1:0] nm,
                          input logic ns);
      logic ebits [0:11];
      int   nb, n, errs, dcount;
      bit   has_par;
      has_par = (m == 2'b01) || (m == 2'b10);
      ebits[0] = 1'b0;
      for (int i = 0; i < 8; i++) ebits[1+i] = d[i];
      nb = 9;
      if (has_par) begin
         ebits[nb] = exp_par;
         nb = nb + 1;
      end
      ebits[nb] = 1'b1;
      nb = nb + 1;
      if (s) begin
         ebits[nb] = 1'b1;
         nb = nb + 1;
      end
      n = 0; errs = 0; dcount = 0;
      while (TX_busy && n < LIMIT) begin
         line_s[n] = TX_out;
         if (n / N >= nb || TX_out !== ebits[n/N]) errs++;
         if (TX_done) dcount++;
         if (n == 1) begin
            TX_data  = nd;
            par_mode = nm;
            stop2    = ns;
         end
         if (poke_at >= 0 && n == poke_at)     TX_start = 1'b1;
         if (poke_at >= 0 && n == poke_at + 1) TX_start = 1'b0;
         @(negedge CLK);
         n++;
      end
      check({tag, "_busy_len"}, n, exp_len);
      check({tag, "_line_errs"}, errs, 0);
      check({tag, "_done_in_frame"}, dcount, 0);
      check({tag, "_done_pulse"}, TX_done, 1'b1);
      check({tag, "_line_idle"}, TX_out, 1'b1);
      for (int k = 0; k < nb; k++)
         if (k * N + 8 < n)
            check($sformatf("%s_bit%0d", tag, k), line_s[k*N+8], ebits[k]);
   endtask

   initial begin
      int errs, n, dcount;
      logic exp7 [0:9];

      repeat (3) @(negedge CLK);
      check("reset_out", TX_out, 1'b1);
      check("reset_busy", TX_busy, 1'b0);
      check("reset_done", TX_done, 1'b0);
      RST = 1'b0;

      errs = 0;
      repeat (100) begin
         @(negedge CLK);
         if (TX_out !== 1'b1 || TX_busy !== 1'b0 || TX_done !== 1'b0) errs++;
      end
      check("idle_100", errs, 0);

      // 0xA5 even parity (four ones -> 0), one stop
      send(8'hA5, 2'b01, 1'b0, 1'b0);
      capture("a5_even", 8'hA5, 2'b01, 1'b0, 1'b0, 176, -1, 8'hA5, 2'b01, 1'b0);
      @(negedge CLK);
      check("a5_even_done_width", TX_done, 1'b0);

      // 0xA5 odd parity -> 1, two stops
      send(8'hA5, 2'b10, 1'b1, 1'b0);
      capture("a5_odd", 8'hA5, 2'b10, 1'b1, 1'b1, 192, -1, 8'hA5, 2'b10, 1'b1);
      @(negedge CLK);

      send(8'h00, 2'b00, 1'b0, 1'b0);
      capture("z_none", 8'h00, 2'b00, 1'b0, 1'b0, 160, -1, 8'h00, 2'b00, 1'b0);
      @(negedge CLK);
      send(8'h00, 2'b11, 1'b0, 1'b0);
      capture("z_mode3", 8'h00, 2'b11, 1'b0, 1'b0, 160, -1, 8'h00, 2'b11, 1'b0);
      @(negedge CLK);

      // start pulse with 0xFF mid-frame must be ignored
      send(8'hA5, 2'b01, 1'b0, 1'b0);
      capture("poke", 8'hA5, 2'b01, 1'b0, 1'b0, 176, 40, 8'hFF, 2'b10, 1'b1);
      @(negedge CLK);
      check("poke_no_restart", TX_busy, 1'b0);

      // back-to-back: 0x3C even/1 stop, then 0xC3 odd (four ones -> 1)/2 stops
      send(8'h3C, 2'b01, 1'b0, 1'b1);
      capture("b2b_1", 8'h3C, 2'b01, 1'b0, 1'b0, 176, -1, 8'hC3, 2'b10, 1'b1);
      @(negedge CLK);
      check("b2b_gap_busy", TX_busy, 1'b1);
      check("b2b_gap_start", TX_out, 1'b0);
      check("b2b_done_width", TX_done, 1'b0);
      TX_start = 1'b0;
      capture("b2b_2", 8'hC3, 2'b10, 1'b1, 1'b1, 192, -1, 8'hC3, 2'b10, 1'b1);
      @(negedge CLK);

      // reset during DATA
      send(8'h96, 2'b01, 1'b0, 1'b0);
      repeat (60) @(negedge CLK);
      check("pre_rst_busy", TX_busy, 1'b1);
      @(posedge CLK);
      #2 RST = 1'b1;
      #1;
      check("rst_out_now", TX_out, 1'b1);
      check("rst_busy_now", TX_busy, 1'b0);
      errs = 0;
      repeat (3) begin
         @(negedge CLK);
         if (TX_done !== 1'b0 || TX_out !== 1'b1) errs++;
      end
      RST = 1'b0;
      repeat (5) begin
         @(negedge CLK);
         if (TX_done !== 1'b0 || TX_out !== 1'b1 || TX_busy !== 1'b0) errs++;
      end
      check("rst_quiet", errs, 0);
      send(8'h5A, 2'b01, 1'b0, 1'b0);
      capture("post_rst", 8'h5A, 2'b01, 1'b0, 1'b0, 176, -1, 8'h5A, 2'b01, 1'b0);
      @(negedge CLK);

      // 7-bit, 4 clk/bit: 0x55 even parity 0 -> 0,1,0,1,0,1,0,1,0,1
      exp7 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tx_data7  = 7'h55;
      tx_start7 = 1'b1;
      @(negedge CLK);
      tx_start7 = 1'b0;
      n = 0; errs = 0; dcount = 0;
      while (busy7 && n < 200) begin
         if (n / 4 >= 10 || out7 !== exp7[n/4]) errs++;
         if (done7) dcount++;
         @(negedge CLK);
         n++;
      end
      check("w7_busy_len", n, 40);
      check("w7_line_errs", errs, 0);
      check("w7_done_in_frame", dcount, 0);
      check("w7_done_pulse", done7, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
